// File: rtl/mmio_initiator.sv
// mmio_initiator: turns single core load/store requests into timed accesses
// on the 16-bit peripheral bus, one transaction in flight at a time.
// Each access lasts WAIT_CYCLES+1 bus cycles; the write strobe is asserted only
// in the final cycle, and read data is sampled at the edge that closes it.
module mmio_initiator #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rdata,
    output logic        rsp_we,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_wdata,
    output logic        bus_we,
    input  logic [15:0] bus_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic        we_lat;
    logic        accept;
    logic        final_cyc;

    // Handshake and status decode straight from the state register, so no
    // request-side input can reach an output combinationally.
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = req_ready && req_valid;
    assign final_cyc = (state == ACCESS) && (cnt == 4'd0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: IDLE -> ACCESS on accept, ACCESS -> RESP when the
    // counter has run out, RESP -> IDLE once the core takes the response.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Latch the request and count down the wait states; the counter stops at
    // zero because the FSM leaves ACCESS in that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_addr  <= 16'h0000;
            bus_wdata <= 16'h0000;
            we_lat    <= 1'b0;
            cnt       <= 4'd0;
        end else if (accept) begin
            bus_addr  <= req_addr;
            bus_wdata <= req_wdata;
            we_lat    <= req_we;
            cnt       <= WAIT_INIT;
        end else if ((state == ACCESS) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Registered write strobe: raised on the edge entering the final access
    // cycle, so a store produces exactly one strobe cycle; an async reset
    // drops it immediately and aborts the access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_we <= 1'b0;
        end else if (accept) begin
            bus_we <= req_we && (WAIT_INIT == 4'd0);
        end else if ((state == ACCESS) && (cnt == 4'd1)) begin
            bus_we <= we_lat;
        end else begin
            bus_we <= 1'b0;
        end
    end

    // Response capture at the close of the final access cycle; the values are
    // then held untouched for as long as the core back-pressures.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 16'h0000;
            rsp_we    <= 1'b0;
        end else begin
            rsp_valid <= (state_nxt == RESP);
            if (final_cyc) begin
                rsp_rdata <= we_lat ? 16'h0000 : bus_rdata;
                rsp_we    <= we_lat;
            end
        end
    end

endmodule

// File: tb/tb_mmio_initiator.sv
// Directed bench for mmio_initiator: four instances with WAIT_CYCLES of
// 0, 1, 3 and 15, each attached to a small GPIO-like responder
// (0x0000: write out register / read gpio_in, 0x0004: dir register,
// anything else reads as zero).
module tb_mmio_initiator;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        req_valid [N];
    logic        req_we    [N];
    logic [15:0] req_addr  [N];
    logic [15:0] req_wdata [N];
    logic        rsp_ready [N];
    logic [15:0] gpio_in   [N];
    logic [15:0] rd_flip   [N];

    logic        req_ready [N];
    logic        rsp_valid [N];
    logic [15:0] rsp_rdata [N];
    logic        rsp_we    [N];
    logic [15:0] bus_addr  [N];
    logic [15:0] bus_wdata [N];
    logic        bus_we    [N];
    logic        busy      [N];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_n = 0;
    int acc1  = 0;
    int acc2  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        logic [15:0] out_r  = 16'hBEEF;
        logic [15:0] dir_r  = 16'h0000;
        int          we_cnt = 0;
        logic [15:0] rdata;

        always @(posedge clk) begin
            if (bus_we[g]) begin
                we_cnt <= we_cnt + 1;
                if (bus_addr[g] == 16'h0000) out_r <= bus_wdata[g];
                if (bus_addr[g] == 16'h0004) dir_r <= bus_wdata[g];
            end
        end

        always_comb begin
            rdata = 16'h0000;
            if (bus_addr[g] == 16'h0000) rdata = gpio_in[g];
            if (bus_addr[g] == 16'h0004) rdata = dir_r;
            rdata = rdata ^ rd_flip[g];
        end

        mmio_initiator #(
            .WAIT_CYCLES((g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 3 : 15)
        ) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_we    (req_we[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_we    (rsp_we[g]),
            .bus_addr  (bus_addr[g]),
            .bus_wdata (bus_wdata[g]),
            .bus_we    (bus_we[g]),
            .bus_rdata (rdata),
            .busy      (busy[g])
        );
    end

    // Cycle counter and accept recorder for the back-to-back instance.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (req_valid[2] && req_ready[2]) begin
            if (acc_n == 0) acc1 <= cyc;
            else            acc2 <= cyc;
            acc_n <= acc_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send(input int i, input logic we, input logic [15:0] a, input logic [15:0] d);
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_addr[i]  = a;
        req_wdata[i] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = 1'b0;
            req_we[i]    = 1'b0;
            req_addr[i]  = 16'h0000;
            req_wdata[i] = 16'h0000;
            rsp_ready[i] = 1'b0;
            gpio_in[i]   = 16'h0000;
            rd_flip[i]   = 16'h0000;
        end
        repeat (2) tick();

        // Reset values on every instance.
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rst_req_ready%0d", i), req_ready[i], 1'b1);
            chk($sformatf("rst_rsp_valid%0d", i), rsp_valid[i], 1'b0);
            chk($sformatf("rst_rsp_rdata%0d", i), rsp_rdata[i], 16'h0000);
            chk($sformatf("rst_rsp_we%0d", i), rsp_we[i], 1'b0);
            chk($sformatf("rst_bus_addr%0d", i), bus_addr[i], 16'h0000);
            chk($sformatf("rst_bus_wdata%0d", i), bus_wdata[i], 16'h0000);
            chk($sformatf("rst_bus_we%0d", i), bus_we[i], 1'b0);
            chk($sformatf("rst_busy%0d", i), busy[i], 1'b0);
        end
        rst_n = 1'b1;
        tick();

        // Reset in the strobe cycle of a store to 0x0000 (WAIT_CYCLES=1).
        send(1, 1'b1, 16'h0000, 16'h1234);
        tick();
        req_valid[1] = 1'b0;
        chk("abort_busy", busy[1], 1'b1);
        chk("abort_we_c1", bus_we[1], 1'b0);
        tick();
        chk("abort_we_c2", bus_we[1], 1'b1);
        rst_n = 1'b0;
        #1;
        chk("abort_we_drop", bus_we[1], 1'b0);
        chk("abort_rsp_valid", rsp_valid[1], 1'b0);
        chk("abort_busy_drop", busy[1], 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("abort_req_ready", req_ready[1], 1'b1);
        chk("abort_no_rsp", rsp_valid[1], 1'b0);
        chk("abort_out_r", g_dut[1].out_r, 16'hBEEF);
        chk("abort_we_cnt", g_dut[1].we_cnt, 0);

        // Store 0x0004 <- 0x00A5, WAIT_CYCLES=1.
        send(1, 1'b1, 16'h0004, 16'h00A5);
        tick();
        req_valid[1] = 1'b0;
        chk("st_req_ready", req_ready[1], 1'b0);
        chk("st_bus_addr", bus_addr[1], 16'h0004);
        chk("st_bus_wdata", bus_wdata[1], 16'h00A5);
        chk("st_we_c1", bus_we[1], 1'b0);
        tick();
        chk("st_we_c2", bus_we[1], 1'b1);
        chk("st_rsp_early", rsp_valid[1], 1'b0);
        tick();
        chk("st_we_after", bus_we[1], 1'b0);
        chk("st_rsp_valid", rsp_valid[1], 1'b1);
        chk("st_rsp_rdata", rsp_rdata[1], 16'h0000);
        chk("st_rsp_we", rsp_we[1], 1'b1);
        chk("st_dir", g_dut[1].dir_r, 16'h00A5);
        chk("st_we_cnt", g_dut[1].we_cnt, 1);
        rsp_ready[1] = 1'b1;
        tick();
        rsp_ready[1] = 1'b0;
        chk("st_rsp_done", rsp_valid[1], 1'b0);
        chk("st_idle_ready", req_ready[1], 1'b1);

        // Load 0x0000 with gpio_in=0x3C, WAIT_CYCLES=0.
        gpio_in[0] = 16'h003C;
        send(0, 1'b0, 16'h0000, 16'h0000);
        tick();
        req_valid[0] = 1'b0;
        chk("ld_rsp_early", rsp_valid[0], 1'b0);
        chk("ld_we", bus_we[0], 1'b0);
        tick();
        chk("ld_rsp_valid", rsp_valid[0], 1'b1);
        chk("ld_rsp_rdata", rsp_rdata[0], 16'h003C);
        chk("ld_rsp_we", rsp_we[0], 1'b0);
        chk("ld_we_cnt", g_dut[0].we_cnt, 0);
        rsp_ready[0] = 1'b1;
        tick();
        rsp_ready[0] = 1'b0;
        chk("ld_idle_ready", req_ready[0], 1'b1);

        // Backpressure: load 0x0004 (dir=0xA5), response held for 5 cycles.
        send(1, 1'b0, 16'h0004, 16'h0000);
        tick();
        req_valid[1] = 1'b0;
        tick();
        tick();
        chk("bp_rsp_valid0", rsp_valid[1], 1'b1);
        chk("bp_rsp_rdata0", rsp_rdata[1], 16'h00A5);
        for (int k = 0; k < 5; k++) begin
            rd_flip[1]   = 16'(k + 1) << 4;
            req_valid[1] = (k % 2 == 0);
            req_addr[1]  = 16'h0000;
            tick();
            chk($sformatf("bp_rsp_valid_k%0d", k), rsp_valid[1], 1'b1);
            chk($sformatf("bp_rsp_rdata_k%0d", k), rsp_rdata[1], 16'h00A5);
            chk($sformatf("bp_req_ready_k%0d", k), req_ready[1], 1'b0);
            chk($sformatf("bp_bus_addr_k%0d", k), bus_addr[1], 16'h0004);
        end
        req_valid[1] = 1'b0;
        rd_flip[1]   = 16'h0000;
        rsp_ready[1] = 1'b1;
        tick();
        rsp_ready[1] = 1'b0;
        chk("bp_idle_ready", req_ready[1], 1'b1);
        chk("bp_busy", busy[1], 1'b0);
        chk("bp_no_second", bus_addr[1], 16'h0004);

        // Back-to-back, WAIT_CYCLES=3, rsp_ready held high.
        rsp_ready[2] = 1'b1;
        gpio_in[2]   = 16'h0077;
        send(2, 1'b1, 16'h0000, 16'h0011);
        tick();
        req_we[2]    = 1'b0;
        req_addr[2]  = 16'h0008;
        req_wdata[2] = 16'h0000;
        for (int k = 0; k < 20 && acc_n < 2; k++) tick();
        req_valid[2] = 1'b0;
        chk("b2b_accepts", acc_n, 2);
        chk("b2b_spacing", acc2 - acc1, 6);
        chk("b2b_out_r", g_dut[2].out_r, 16'h0011);
        for (int k = 0; k < 10 && !rsp_valid[2]; k++) tick();
        chk("b2b_rsp_valid", rsp_valid[2], 1'b1);
        chk("b2b_rsp_rdata", rsp_rdata[2], 16'h0000);
        chk("b2b_rsp_we", rsp_we[2], 1'b0);
        tick();
        rsp_ready[2] = 1'b0;
        chk("b2b_idle", busy[2], 1'b0);

        // WAIT_CYCLES=15 store: 16 access cycles, strobe only on the 16th.
        send(3, 1'b1, 16'h0004, 16'h5555);
        tick();
        req_valid[3] = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            chk($sformatf("w15_we_c%0d", k), bus_we[3], (k == 16));
            chk($sformatf("w15_rsp_c%0d", k), rsp_valid[3], 1'b0);
            tick();
        end
        chk("w15_rsp_valid", rsp_valid[3], 1'b1);
        chk("w15_rsp_we", rsp_we[3], 1'b1);
        chk("w15_dir", g_dut[3].dir_r, 16'h5555);
        chk("w15_we_cnt", g_dut[3].we_cnt, 1);
        rsp_ready[3] = 1'b1;
        tick();
        rsp_ready[3] = 1'b0;
        chk("w15_idle_ready", req_ready[3], 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mmio_initiator.md
# mmio_initiator

Bus initiator that turns single load/store requests from the processor core into accesses on the 16-bit peripheral bus that GPIO and the other memory-mapped responders sit on. Requests arrive over a valid/ready handshake. The block drives `bus_addr`/`bus_wdata`/`bus_we` for a parameterised number of wait states, samples `bus_rdata` on the final access cycle, and returns a response over a second valid/ready handshake. It allows one outstanding transaction at a time and sits between the core's load/store unit and the peripheral address decoder.

## Interface
Parameters:
- `WAIT_CYCLES`, default 1: extra bus cycles per access; legal range 0..15.

Ports:
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  core request present.
- `req_ready`  out  1  block can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  16  target address.
- `req_wdata`  in  16  store data.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  core accepts the response.
- `rsp_rdata`  out  16  load data; 0 for stores.
- `rsp_we`  out  1  echo of the `req_we` of the completed transaction.
- `bus_addr`  out  16  peripheral address.
- `bus_wdata`  out  16  peripheral write data.
- `bus_we`  out  1  peripheral write strobe.
- `bus_rdata`  in  16  peripheral read data; combinational from `bus_addr`.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- The FSM has three states: IDLE, ACCESS, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid && req_ready`, latch `req_addr`, `req_wdata` and `req_we`.
  - Load the wait counter with `WAIT_CYCLES` and go to ACCESS.
- ACCESS:
  - `bus_addr` and `bus_wdata` drive the latched values.
  - The counter decrements each cycle. The cycle in which the counter = 0 is the final access cycle.
  - `bus_we` = latched `we` only in the final access cycle. Exactly one write strobe is issued per store.
  - At the end of the final cycle: if load, capture `bus_rdata` into `rsp_rdata`; if store, set `rsp_rdata`=0. Then go to RESP.
- RESP:
  - `rsp_valid`=1, and `rsp_rdata`/`rsp_we` are held stable.
  - On `rsp_ready`, go to IDLE.
  - `rsp_valid` stays high until accepted, regardless of `req_valid`.
- `req_ready`=0 in ACCESS and RESP. A `req_valid` asserted in those states is ignored and must be held by the core.
- `bus_addr` and `bus_wdata` keep the last latched values outside ACCESS. `bus_we`=0 outside the final access cycle.
- The wait counter is 4 bits wide. It never underflows because the state changes at 0.

## Timing
- Reset (async assert, any state): state=IDLE; `req_ready`=1 after reset; `rsp_valid`=0, `rsp_rdata`=0, `rsp_we`=0, `bus_addr`=0, `bus_wdata`=0, `bus_we`=0, `busy`=0, counter=0.
- Reset mid-ACCESS aborts the access immediately. `bus_we` drops asynchronously and no response is produced.
- Request accepted at edge E0:
  - ACCESS occupies cycles E0..E0+WAIT_CYCLES+1, i.e. WAIT_CYCLES+1 cycles.
  - `rsp_valid` rises after edge E0+WAIT_CYCLES+1.
  - Request-to-response latency is WAIT_CYCLES+1 cycles. With `WAIT_CYCLES`=0, `rsp_valid` rises after E0+1.
- If `rsp_ready` is already high when `rsp_valid` rises, RESP lasts one cycle. IDLE follows, and `req_ready`=1 on the next cycle.
- Minimum transaction period is WAIT_CYCLES+3 cycles.
- The `bus_rdata` sample point is the edge closing the final ACCESS cycle. Changes to `bus_rdata` in earlier ACCESS cycles are not visible.
- All outputs are registered except `req_ready` and `busy`, which decode directly from the state register. No combinational path exists from `req_*`/`rsp_ready` to any output.

## Test plan
- Reset: assert `rst_n`=0 mid-ACCESS of a store to 0x0000 → `bus_we`=0 at once, `rsp_valid`=0, `req_ready`=1 after release, and the responder register is unchanged.
- Store, `WAIT_CYCLES`=1: req `we`=1, addr 0x0004, wdata 0x00A5 →
  - `bus_we` high for exactly one cycle, in the 2nd ACCESS cycle;
  - responder dir register = 0xA5;
  - `rsp_valid` 2 cycles after accept, `rsp_rdata`=0x0000, `rsp_we`=1.
- Load, `WAIT_CYCLES`=0: `gpio_in`=0x3C, read addr 0x0000 → `bus_we` never high, `rsp_rdata`=0x003C one cycle after accept.
- Backpressure: hold `rsp_ready`=0 for 5 cycles after a load of 0x0004 (dir=0xA5); change `bus_rdata` and pulse `req_valid` meanwhile → `rsp_valid` held, `rsp_rdata` stays 0x00A5, no second access starts, `req_ready`=0 throughout.
- Back-to-back: `req_valid` held high with store 0x0000←0x0011 then load 0x0008, `rsp_ready`=1 constantly, `WAIT_CYCLES`=3 → accepts spaced 6 cycles apart, second `rsp_rdata`=0x0000 (unmapped address).
- Wait-state extreme: `WAIT_CYCLES`=15, store → 16 ACCESS cycles, a single `bus_we` pulse on the 16th, no counter wrap.
